// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep scheduler: steps fre_k from start to stop with a per-point dwell.
// Optional SWEEP_BIDIR_EN macro makes continuous mode triangular instead of sawtooth.
module dds_sweep_ctrl #(
    parameter int              FW_W    = 32,
    parameter int              DWELL_W = 24,
    parameter logic [FW_W-1:0] RST_FW  = 32'd34360
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [FW_W-1:0]    cfg_start,
    input  logic [FW_W-1:0]    cfg_stop,
    input  logic [FW_W-1:0]    cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [FW_W-1:0]    fre_k,
    output logic               busy,
    output logic               sweep_sync,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;
    localparam logic [1:0] STEP  = 2'd3;

    logic [1:0]         state;
    logic [FW_W-1:0]    start_s;
    logic [FW_W-1:0]    stop_s;
    logic [FW_W-1:0]    step_s;
    logic [DWELL_W-1:0] dwell_s;
    logic               cont_s;
    logic [DWELL_W-1:0] cnt;
    logic [FW_W:0]      nxt;
    logic               top_hit;

    // One extra bit so a carry past the top of the word range counts as overshoot
    always_comb begin
        nxt     = {1'b0, fre_k} + {1'b0, step_s};
        top_hit = (step_s == '0) || (nxt > {1'b0, stop_s});
    end

`ifdef SWEEP_BIDIR_EN
    logic          dir_up;
    logic [FW_W:0] dn;
    logic          bot_hit;

    always_comb begin
        dn      = {1'b0, fre_k} - {1'b0, step_s};
        bot_hit = (step_s == '0) || dn[FW_W] || (dn[FW_W-1:0] < start_s);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fre_k      <= RST_FW;
            busy       <= 1'b0;
            sweep_sync <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            cnt        <= '0;
            start_s    <= '0;
            stop_s     <= '0;
            step_s     <= '0;
            dwell_s    <= '0;
            cont_s     <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir_up     <= 1'b1;
`endif
        end else begin
            sweep_sync <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_start <= cfg_stop) begin
                                start_s <= cfg_start;
                                stop_s  <= cfg_stop;
                                step_s  <= cfg_step;
                                dwell_s <= cfg_dwell;
                                cont_s  <= cont;
                                busy    <= 1'b1;
                                state   <= LOAD;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        fre_k      <= start_s;
                        sweep_sync <= 1'b1;
                        cnt        <= dwell_s;
                        state      <= DWELL;
`ifdef SWEEP_BIDIR_EN
                        dir_up     <= 1'b1;
`endif
                    end
                    DWELL: begin
                        if (cnt == '0) state <= STEP;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: begin
`ifdef SWEEP_BIDIR_EN
                        if (dir_up) begin
                            if (!top_hit) begin
                                fre_k <= nxt[FW_W-1:0];
                                cnt   <= dwell_s;
                                state <= DWELL;
                            end else if (!cont_s) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else if (!bot_hit) begin
                                fre_k      <= dn[FW_W-1:0];
                                dir_up     <= 1'b0;
                                sweep_sync <= (dn[FW_W-1:0] == start_s);
                                cnt        <= dwell_s;
                                state      <= DWELL;
                            end else begin
                                state <= LOAD;
                            end
                        end else begin
                            if (!bot_hit) begin
                                fre_k      <= dn[FW_W-1:0];
                                sweep_sync <= (dn[FW_W-1:0] == start_s);
                                cnt        <= dwell_s;
                                state      <= DWELL;
                            end else if (!top_hit) begin
                                fre_k  <= nxt[FW_W-1:0];
                                dir_up <= 1'b1;
                                cnt    <= dwell_s;
                                state  <= DWELL;
                            end else begin
                                state <= LOAD;
                            end
                        end
`else
                        if (!top_hit) begin
                            fre_k <= nxt[FW_W-1:0];
                            cnt   <= dwell_s;
                            state <= DWELL;
                        end else if (cont_s) begin
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized self-checking bench for dds_sweep_ctrl (default sawtooth build).
// Expected traces come from a point-list/timeline model of the sweep.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cont;
    logic [31:0] cfg_start;
    logic [31:0] cfg_stop;
    logic [31:0] cfg_step;
    logic [23:0] cfg_dwell;
    logic [31:0] fre_k;
    logic        busy;
    logic        sweep_sync;
    logic        done;
    logic        cfg_err;

    dds_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .fre_k(fre_k), .busy(busy),
        .sweep_sync(sweep_sync), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_fk;
    logic [31:0] pts[$];
    int          m_dwell;
    bit          m_cont;
    logic [31:0] m_f0;

    // Grid points start + n*step that do not exceed stop (64-bit, no wrap)
    function automatic void build(input logic [31:0] s, input logic [31:0] e,
                                  input logic [31:0] st);
        logic [63:0] v;
        pts.delete();
        v = {32'd0, s};
        if (st == 32'd0) pts.push_back(s);
        else begin
            while (v <= {32'd0, e} && pts.size() < 4096) begin
                pts.push_back(v[31:0]);
                v = v + {32'd0, st};
            end
        end
    endfunction

    // Expected {fre_k, busy, sweep_sync, done} in cycle c after the start edge
    function automatic logic [34:0] expect_at(input int c);
        int L;
        int S;
        int t;
        L = pts.size();
        S = m_dwell + 2;
        t = c - 2;
        if (c == 1) return {m_f0, 3'b100};
        if (m_cont) begin
            int u;
            u = t % (L * S + 1);
            if (u == L * S) return {pts[L-1], 3'b100};
            return {pts[u / S], 1'b1, (u == 0), 1'b0};
        end
        if (t < L * S) return {pts[t / S], 1'b1, (t == 0), 1'b0};
        if (t == L * S) return {pts[L-1], 3'b001};
        return {pts[L-1], 3'b000};
    endfunction

    task automatic launch(input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] st, input int d, input bit c);
        cfg_start = s;
        cfg_stop  = e;
        cfg_step  = st;
        cfg_dwell = d[23:0];
        cont      = c;
        start     = 1'b1;
        m_dwell   = d;
        m_cont    = c;
        m_f0      = exp_fk;
        build(s, e, st);
        @(negedge clk);
        start     = 1'b0;
        cfg_start = $urandom;
        cfg_stop  = $urandom;
        cfg_step  = $urandom;
        cfg_dwell = 24'($urandom);
        cont      = 1'($urandom);
    endtask

    task automatic track(input string name, input int n, input int poke);
        logic [35:0] got;
        logic [35:0] exp;
        for (int c = 1; c <= n; c++) begin
            got = {fre_k, busy, sweep_sync, done, cfg_err};
            exp = {expect_at(c), 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cyc%0d: got fk=%0h b=%b s=%b d=%b e=%b want fk=%0h b=%b s=%b d=%b e=%b",
                         name, c, got[35:4], got[3], got[2], got[1], got[0],
                         exp[35:4], exp[3], exp[2], exp[1], exp[0]);
            end
            exp_fk = exp[35:4];
            start = (c == poke);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic abort_at(input string name, input int c);
        logic [34:0] e;
        e = expect_at(c);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (fre_k !== e[34:3] || busy !== 1'b0 || done !== 1'b0 || sweep_sync !== 1'b0) begin
            errors++;
            $display("FAIL %s abort: got fk=%0h b=%b d=%b s=%b want fk=%0h b=0 d=0 s=0",
                     name, fre_k, busy, done, sweep_sync, e[34:3]);
        end
        exp_fk = e[34:3];
        repeat (3) @(negedge clk);
        checks++;
        if (fre_k !== exp_fk || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s post_abort: got fk=%0h b=%b d=%b want fk=%0h b=0 d=0",
                     name, fre_k, busy, done, exp_fk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cont  = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_step  = '0;
        cfg_dwell = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (fre_k !== 32'd34360 || busy !== 1'b0 || sweep_sync !== 1'b0 ||
            done !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got fk=%0d b=%b s=%b d=%b e=%b want fk=34360 all 0",
                     fre_k, busy, sweep_sync, done, cfg_err);
        end
        rst_n  = 1'b1;
        exp_fk = 32'd34360;
        @(negedge clk);
    endtask

    task automatic test_single;
        launch(32'd100, 32'd400, 32'd100, 3, 1'b0);
        track("single", 4 * 5 + 4, 7);
        checks++;
        if (fre_k !== 32'd400 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got fk=%0d b=%b want fk=400 b=0", fre_k, busy);
        end
    endtask

    task automatic test_overflow;
        launch(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 2, 1'b0);
        track("overflow", 2 * 4 + 4, -1);
        checks++;
        if (fre_k !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL overflow_end: got fk=%0h want ffffff80", fre_k);
        end
    endtask

    task automatic test_continuous;
        launch(32'd10, 32'd30, 32'd10, 0, 1'b1);
        track("continuous", 30, 9);
        abort_at("continuous", 31);
    endtask

    task automatic test_cfg_err;
        cfg_start = 32'd500;
        cfg_stop  = 32'd100;
        cfg_step  = 32'd10;
        cfg_dwell = 24'd1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || fre_k !== exp_fk) begin
            errors++;
            $display("FAIL cfg_err_pulse: got e=%b b=%b fk=%0h want e=1 b=0 fk=%0h",
                     cfg_err, busy, fre_k, exp_fk);
        end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear: got e=%b b=%b want e=0 b=0", cfg_err, busy);
        end
        cfg_start = 32'd5;
        cfg_stop  = 32'd50;
        start     = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fre_k !== exp_fk || sweep_sync !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort: got b=%b fk=%0h s=%b want b=0 fk=%0h s=0",
                     busy, fre_k, sweep_sync, exp_fk);
        end
    endtask

    task automatic test_abort_dwell;
        launch(32'd2000, 32'd9000, 32'd1000, 5, 1'b0);
        track("abort_dwell", 10, -1);
        abort_at("abort_dwell", 11);
    endtask

    task automatic test_step_zero;
        launch(32'd777, 32'd777, 32'd0, 2, 1'b0);
        track("step_zero", 8, 3);
        checks++;
        if (fre_k !== 32'd777 || busy !== 1'b0) begin
            errors++;
            $display("FAIL step_zero_end: got fk=%0d b=%b want fk=777 b=0", fre_k, busy);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] s;
            logic [31:0] st;
            logic [63:0] e64;
            int          np;
            int          d;
            bit          c;
            int          len;
            s  = $urandom;
            st = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            np = $urandom_range(1, 5);
            d  = $urandom_range(0, 3);
            c  = 1'($urandom);
            if (st == 32'd0)
                e64 = {32'd0, s} + 64'($urandom_range(0, 50));
            else
                e64 = {32'd0, s} + 64'(np - 1) * {32'd0, st} +
                      64'($urandom_range(0, st - 1));
            if (e64 > 64'h0000_0000_FFFF_FFFF) e64 = 64'h0000_0000_FFFF_FFFF;
            launch(s, e64[31:0], st, d, c);
            len = pts.size() * (d + 2);
            if (c) begin
                track("random_cont", 2 * (len + 1) + 3, $urandom_range(1, len));
                abort_at("random_cont", 2 * (len + 1) + 4);
            end else begin
                track("random_single", len + 4, $urandom_range(1, len));
            end
        end
    endtask

    task automatic test_reset_mid;
        launch(32'd1000, 32'd5000, 32'd1000, 6, 1'b1);
        track("reset_mid", 5, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fre_k !== 32'd34360 || busy !== 1'b0 || sweep_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got fk=%0d b=%b s=%b want fk=34360 b=0 s=0",
                     fre_k, busy, sweep_sync);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        exp_fk = 32'd34360;
        repeat (2) @(negedge clk);
        checks++;
        if (fre_k !== 32'd34360 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got fk=%0d b=%b want fk=34360 b=0", fre_k, busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_overflow;
        test_continuous;
        test_cfg_err;
        test_abort_dwell;
        test_step_zero;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
